// File: rtl/retire_halt_monitor_if.sv
// Bundles the writeback retirement stream, the history read port and the
// monitor status outputs.
interface retire_halt_monitor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32,
    parameter int DEPTH = 8
);
    localparam int IDX_W = $clog2(DEPTH);

    logic             valid_w;
    logic [XLEN-1:0]  pc_w;
    logic [IDX_W-1:0] hist_idx;
    logic [XLEN-1:0]  hist_pc;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;
    logic             done;
    logic             pass;
    logic [1:0]       halt_cause;

    // Core or harness side: drives retirements and reads status.
    modport master (
        output valid_w, pc_w, hist_idx,
        input  hist_pc, cycle_cnt, retire_cnt, done, pass, halt_cause
    );

    // Monitor side.
    modport slave (
        input  valid_w, pc_w, hist_idx,
        output hist_pc, cycle_cnt, retire_cnt, done, pass, halt_cause
    );
endinterface

// File: rtl/retire_halt_monitor.sv
// Retirement monitor: counts cycles/retirements and halts on END_PC, a PC
// self-loop or a retirement watchdog. PC history is built only with MON_HIST_EN.
module retire_halt_monitor #(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] END_PC  = 32'h0000000c,
    parameter int              TIMEOUT = 1024,
    parameter int              CNT_W   = 32,
    parameter int              DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    retire_halt_monitor_if.slave  mon
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        HUNG = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cycle_cnt_r;
    logic [CNT_W-1:0] retire_cnt_r;
    logic [WD_W-1:0]  wd_r;
    logic [XLEN-1:0]  prev_pc_r;
    logic             have_prev_r;
    logic             done_r;
    logic             pass_r;
    logic [1:0]       cause_r;

    logic active_s;
    logic retire_s;
    logic end_hit_s;
    logic loop_hit_s;
    logic wd_expire_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign active_s    = (state_r == IDLE) || (state_r == RUN);
    assign retire_s    = active_s && mon.valid_w;
    assign end_hit_s   = retire_s && (mon.pc_w == END_PC);
    // have_prev_r keeps the post-reset zero PC from looking like a self-loop.
    assign loop_hit_s  = retire_s && have_prev_r && (mon.pc_w == prev_pc_r);
    assign wd_expire_s = active_s && !mon.valid_w && (wd_r == WD_W'(TIMEOUT - 1));

    // Monitor FSM with counters, watchdog and registered halt status.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r      <= IDLE;
            cycle_cnt_r  <= {CNT_W{1'b0}};
            retire_cnt_r <= {CNT_W{1'b0}};
            wd_r         <= {WD_W{1'b0}};
            prev_pc_r    <= {XLEN{1'b0}};
            have_prev_r  <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            cause_r      <= 2'b00;
        end else begin
            case (state_r)
                IDLE, RUN: begin
                    if ((state_r == RUN) || mon.valid_w) begin
                        cycle_cnt_r <= sat_inc(cycle_cnt_r);
                    end
                    if (mon.valid_w) begin
                        retire_cnt_r <= sat_inc(retire_cnt_r);
                        prev_pc_r    <= mon.pc_w;
                        have_prev_r  <= 1'b1;
                        wd_r         <= {WD_W{1'b0}};
                    end else begin
                        wd_r <= wd_r + WD_W'(1);
                    end

                    if (end_hit_s) begin
                        state_r <= HALT;
                        done_r  <= 1'b1;
                        pass_r  <= 1'b1;
                        cause_r <= 2'b01;
                    end else if (loop_hit_s) begin
                        state_r <= HALT;
                        done_r  <= 1'b1;
                        cause_r <= 2'b10;
                    end else if (wd_expire_s) begin
                        state_r <= HUNG;
                        done_r  <= 1'b1;
                        cause_r <= 2'b11;
                    end else if (mon.valid_w) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= state_r;
                    end
                end
                HALT, HUNG: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign mon.cycle_cnt  = cycle_cnt_r;
    assign mon.retire_cnt = retire_cnt_r;
    assign mon.done       = done_r;
    assign mon.pass       = pass_r;
    assign mon.halt_cause = cause_r;

`ifdef MON_HIST_EN
    logic [XLEN-1:0]  hist_r [DEPTH];
    logic [IDX_W-1:0] wr_ptr_r;
    logic [IDX_W-1:0] rd_ptr_s;

    // Ring buffer of counted retirements, including the one that halts.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_r[i] <= {XLEN{1'b0}};
            end
            wr_ptr_r <= {IDX_W{1'b0}};
        end else if (retire_s) begin
            hist_r[wr_ptr_r] <= mon.pc_w;
            wr_ptr_r         <= wr_ptr_r + IDX_W'(1);
        end
    end

    // DEPTH is a power of two, so the IDX_W-bit subtraction is the modulo.
    assign rd_ptr_s    = wr_ptr_r - IDX_W'(1) - mon.hist_idx;
    assign mon.hist_pc = hist_r[rd_ptr_s];
`else
    assign mon.hist_pc = {XLEN{1'b0}};
`endif

endmodule
